// File: rtl/branch_pkg.sv
// Shared branch codes and 2-bit predictor counter states for the EX-stage resolver.
package branch_pkg;

    localparam logic [4:0] BR_NONE   = 5'd0;
    localparam logic [4:0] BR_BEQ    = 5'd1;
    localparam logic [4:0] BR_BNE    = 5'd2;
    localparam logic [4:0] BR_BGEZ   = 5'd3;
    localparam logic [4:0] BR_BGTZ   = 5'd4;
    localparam logic [4:0] BR_BLEZ   = 5'd5;
    localparam logic [4:0] BR_BLTZ   = 5'd6;
    localparam logic [4:0] BR_BGEZAL = 5'd7;
    localparam logic [4:0] BR_BLTZAL = 5'd8;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one fetch read port, one EX train port.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [BHT_DEPTH-1:0][1:0] cnt_q;
    logic [1:0]                wr_cur;
    logic [1:0]                wr_next;

    always_comb begin
        wr_cur = cnt_q[wr_idx];
        if (wr_taken) begin
            wr_next = (wr_cur == ST) ? ST : wr_cur + 2'd1;
        end else begin
            wr_next = (wr_cur == SNT) ? SNT : wr_cur - 2'd1;
        end
    end

    // Same-index read sees the value being written this cycle.
    always_comb begin
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_taken = wr_next[1];
        end else begin
            rd_taken = cnt_q[rd_idx][1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {BHT_DEPTH{WNT}};
        end else if (wr_en) begin
            cnt_q[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_resolve_ex.sv
// EX-stage branch resolver: outcome, mispredict redirect, jump-conflict flush, BHT training
// and resolved/mispredict statistics.
module branch_resolve_ex
    import branch_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic [4:0]       branch_judge_controlE,
    input  logic [31:0]      pc_plus4E,
    input  logic [31:0]      pcbranchE,
    input  logic             jump_conflictE,
    input  logic [31:0]      rs_valueE,
    input  logic [31:0]      rt_valueE,
    input  logic             pred_takenE,
    input  logic [31:0]      pcF,
    output logic             pred_takenF,
    output logic             actual_takenE,
    output logic             mispredictE,
    output logic [31:0]      redirect_pcE,
    output logic             flush_jumpE,
    output logic             link_enE,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic        is_br;
    logic        cond;
    logic        rs_zero;
    logic        train_en;
    logic [31:0] train_pc;
    logic        unused_pc;

    assign rs_zero = (rs_valueE == 32'd0);
    assign is_br   = (branch_judge_controlE >= BR_BEQ) && (branch_judge_controlE <= BR_BLTZAL);

    // Signed compares against zero reduce to sign-bit and zero tests.
    always_comb begin
        cond = 1'b0;
        case (branch_judge_controlE)
            BR_BEQ:              cond = (rs_valueE == rt_valueE);
            BR_BNE:              cond = (rs_valueE != rt_valueE);
            BR_BGEZ, BR_BGEZAL:  cond = ~rs_valueE[31];
            BR_BGTZ:             cond = ~rs_valueE[31] & ~rs_zero;
            BR_BLEZ:             cond = rs_valueE[31] | rs_zero;
            BR_BLTZ, BR_BLTZAL:  cond = rs_valueE[31];
            default:             cond = 1'b0;
        endcase
    end

    assign actual_takenE = is_br & cond;
    assign mispredictE   = is_br & (actual_takenE != pred_takenE);
    assign redirect_pcE  = actual_takenE ? pcbranchE : pc_plus4E + 32'd4;
    assign link_enE      = (branch_judge_controlE == BR_BGEZAL) ||
                           (branch_judge_controlE == BR_BLTZAL);
    assign flush_jumpE   = jump_conflictE & actual_takenE;

    assign train_pc = pc_plus4E - 32'd4;
    assign train_en = is_br & ~stallE & rst;
    assign unused_pc = ^{pcF[31:IDX_W+2], pcF[1:0], train_pc[31:IDX_W+2], train_pc[1:0]};

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pcF[IDX_W+1:2]),
        .rd_taken (pred_takenF),
        .wr_en    (train_en),
        .wr_idx   (train_pc[IDX_W+1:2]),
        .wr_taken (actual_takenE)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (train_en) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredictE && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ex.sv
// Self-checking bench for branch_resolve_ex: vector table, BHT training, stall and reset cases.
module tb_branch_resolve_ex;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallE = 1'b0;
    logic [4:0]  branch_judge_controlE = 5'd0;
    logic [31:0] pc_plus4E = 32'h00400004;
    logic [31:0] pcbranchE = 32'd0;
    logic        jump_conflictE = 1'b0;
    logic [31:0] rs_valueE = 32'd0;
    logic [31:0] rt_valueE = 32'd0;
    logic        pred_takenE = 1'b0;
    logic [31:0] pcF = 32'h00400000;
    logic        pred_takenF;
    logic        actual_takenE;
    logic        mispredictE;
    logic [31:0] redirect_pcE;
    logic        flush_jumpE;
    logic        link_enE;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    branch_resolve_ex #(
        .BHT_DEPTH (64),
        .CNT_W     (32)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .stallE                (stallE),
        .branch_judge_controlE (branch_judge_controlE),
        .pc_plus4E             (pc_plus4E),
        .pcbranchE             (pcbranchE),
        .jump_conflictE        (jump_conflictE),
        .rs_valueE             (rs_valueE),
        .rt_valueE             (rt_valueE),
        .pred_takenE           (pred_takenE),
        .pcF                   (pcF),
        .pred_takenF           (pred_takenF),
        .actual_takenE         (actual_takenE),
        .mispredictE           (mispredictE),
        .redirect_pcE          (redirect_pcE),
        .flush_jumpE           (flush_jumpE),
        .link_enE              (link_enE),
        .branch_cnt            (branch_cnt),
        .mispredict_cnt        (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] rs, rt, pc4, tgt;
        logic        jc, pred, stall;
        logic        e_taken, e_mis, e_flush, e_link;
        logic [31:0] e_redir;
    } vec_t;

    typedef struct {
        logic        taken, mis, flush, link;
        logic [31:0] redir;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_br = 0;
    logic [31:0] m_mis = 0;
    vec_t        tbl[16];
    vec_t        bseq[7];
    logic        bexp[7];

    function automatic vec_t mk(input logic [4:0] code, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] pc4, input logic [31:0] tgt, input logic jc,
                                input logic pred, input logic stall, input logic taken,
                                input logic mis, input logic flush, input logic link,
                                input logic [31:0] redir);
        vec_t v;
        v.code = code; v.rs = rs; v.rt = rt; v.pc4 = pc4; v.tgt = tgt; v.jc = jc;
        v.pred = pred; v.stall = stall; v.e_taken = taken; v.e_mis = mis;
        v.e_flush = flush; v.e_link = link; v.e_redir = redir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One EX cycle: counters checked after the previous edge, then outputs via the scoreboard.
    task automatic run(input vec_t v, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        chk({tag, ".branch_cnt"}, branch_cnt, m_br);
        chk({tag, ".mispredict_cnt"}, mispredict_cnt, m_mis);
        branch_judge_controlE = v.code;
        rs_valueE = v.rs;
        rt_valueE = v.rt;
        pc_plus4E = v.pc4;
        pcbranchE = v.tgt;
        jump_conflictE = v.jc;
        pred_takenE = v.pred;
        stallE = v.stall;
        sb.push_back('{taken: v.e_taken, mis: v.e_mis, flush: v.e_flush, link: v.e_link,
                       redir: v.e_redir});
        #3;
        e = sb.pop_front();
        chk({tag, ".actual_taken"}, {31'd0, actual_takenE}, {31'd0, e.taken});
        chk({tag, ".mispredict"}, {31'd0, mispredictE}, {31'd0, e.mis});
        chk({tag, ".redirect_pc"}, redirect_pcE, e.redir);
        chk({tag, ".flush_jump"}, {31'd0, flush_jumpE}, {31'd0, e.flush});
        chk({tag, ".link_en"}, {31'd0, link_enE}, {31'd0, e.link});
        if (!v.stall && rst && v.code >= 5'd1 && v.code <= 5'd8) begin
            m_br++;
            if (v.e_mis) m_mis++;
        end
    endtask

    initial begin
        tbl[0]  = mk(5'd1, 32'd5, 32'd5, 32'h00400004, 32'h00400100, 0, 0, 0, 1, 1, 0, 0, 32'h00400100);
        tbl[1]  = mk(5'd2, 32'd5, 32'd5, 32'h00400014, 32'h00400100, 0, 0, 0, 0, 0, 0, 0, 32'h00400018);
        tbl[2]  = mk(5'd6, 32'h80000000, 32'd0, 32'h00400014, 32'h00400200, 0, 1, 0, 1, 0, 0, 0,
                     32'h00400200);
        tbl[3]  = mk(5'd6, 32'd0, 32'd0, 32'h00400014, 32'h00400200, 0, 1, 0, 0, 1, 0, 0, 32'h00400018);
        tbl[4]  = mk(5'd3, 32'd0, 32'd9, 32'h00400014, 32'h00400300, 0, 0, 0, 1, 1, 0, 0, 32'h00400300);
        tbl[5]  = mk(5'd4, 32'd0, 32'd0, 32'h00400014, 32'h00400300, 0, 0, 0, 0, 0, 0, 0, 32'h00400018);
        tbl[6]  = mk(5'd5, 32'hFFFFFFFF, 32'd0, 32'h00400014, 32'h00400400, 0, 1, 0, 1, 0, 0, 0,
                     32'h00400400);
        tbl[7]  = mk(5'd7, 32'd7, 32'd0, 32'h00400014, 32'h00400500, 1, 1, 0, 1, 0, 1, 1, 32'h00400500);
        tbl[8]  = mk(5'd7, 32'h80000001, 32'd0, 32'h00400014, 32'h00400500, 1, 0, 0, 0, 0, 0, 1,
                     32'h00400018);
        tbl[9]  = mk(5'd8, 32'hFFFFFFFF, 32'd0, 32'h00400014, 32'h00400600, 0, 0, 0, 1, 1, 0, 1,
                     32'h00400600);
        tbl[10] = mk(5'd0, 32'd3, 32'd3, 32'h00400014, 32'h00400700, 1, 1, 0, 0, 0, 0, 0, 32'h00400018);
        tbl[11] = mk(5'd9, 32'd3, 32'd3, 32'h00400014, 32'h00400700, 1, 1, 0, 0, 0, 0, 0, 32'h00400018);
        tbl[12] = mk(5'd31, 32'd0, 32'd0, 32'h00400014, 32'h00400700, 1, 1, 0, 0, 0, 0, 0, 32'h00400018);
        tbl[13] = mk(5'd2, 32'd1, 32'd2, 32'h00400014, 32'h00400800, 0, 1, 0, 1, 0, 0, 0, 32'h00400800);
        tbl[14] = mk(5'd2, 32'd4, 32'd4, 32'hFFFFFFFC, 32'h00400800, 0, 0, 0, 0, 0, 0, 0, 32'h00000000);
        tbl[15] = mk(5'd1, 32'd1, 32'd2, 32'h00400014, 32'h00400900, 0, 1, 0, 0, 1, 0, 0, 32'h00400018);

        // Reset state.
        #2;
        chk("reset.pred_takenF", {31'd0, pred_takenF}, 32'd0);
        chk("reset.branch_cnt", branch_cnt, 32'd0);
        chk("reset.mispredict_cnt", mispredict_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // Train one PC: T, idle, T, T, N, N, idle; prediction includes the write bypass.
        pcF = 32'h00400040;
        #1;
        chk("bht.initial", {31'd0, pred_takenF}, 32'd0);
        bseq[0] = mk(5'd1, 32'd1, 32'd1, 32'h00400044, 32'h00401000, 0, 0, 0, 1, 1, 0, 0, 32'h00401000);
        bseq[1] = mk(5'd0, 32'd1, 32'd1, 32'h00400044, 32'h00401000, 0, 0, 0, 0, 0, 0, 0, 32'h00400048);
        bseq[2] = bseq[0];
        bseq[3] = bseq[0];
        bseq[4] = mk(5'd2, 32'd1, 32'd1, 32'h00400044, 32'h00401000, 0, 0, 0, 0, 0, 0, 0, 32'h00400048);
        bseq[5] = bseq[4];
        bseq[6] = bseq[1];
        bexp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run(bseq[i], $sformatf("bht%0d", i));
            chk($sformatf("bht%0d.pred_takenF", i), {31'd0, pred_takenF}, {31'd0, bexp[i]});
        end

        // Held branch stalled 3 cycles then released: trains exactly once.
        pcF = 32'h00400080;
        bseq[0] = mk(5'd1, 32'd6, 32'd6, 32'h00400084, 32'h00402000, 0, 0, 1, 1, 1, 0, 0, 32'h00402000);
        for (int i = 0; i < 3; i++) begin
            run(bseq[0], $sformatf("stall%0d", i));
            chk($sformatf("stall%0d.pred_takenF", i), {31'd0, pred_takenF}, 32'd0);
        end
        bseq[1] = bseq[0];
        bseq[1].stall = 1'b0;
        run(bseq[1], "stall_release");
        run(bseq[0], "stall_after");
        chk("stall_after.pred_takenF", {31'd0, pred_takenF}, 32'd1);

        // Asynchronous reset in the middle of a stall.
        rst = 1'b0;
        #1;
        m_br = 0;
        m_mis = 0;
        chk("midrst.branch_cnt", branch_cnt, 32'd0);
        chk("midrst.mispredict_cnt", mispredict_cnt, 32'd0);
        chk("midrst.pred_takenF", {31'd0, pred_takenF}, 32'd0);
        chk("midrst.actual_taken", {31'd0, actual_takenE}, 32'd1);
        stallE = 1'b0;
        @(posedge clk);
        #1;
        chk("inrst.branch_cnt", branch_cnt, 32'd0);
        chk("inrst.pred_takenF", {31'd0, pred_takenF}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        branch_judge_controlE = 5'd0;
        @(posedge clk);
        #1;
        chk("post.branch_cnt", branch_cnt, 32'd0);
        chk("post.pred_takenF", {31'd0, pred_takenF}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ex.md
# branch_resolve_ex

Execute-stage branch resolver, directly downstream of the ID/EX pipeline register. Consumes the registered branch control code, `pc_plus4E`, `pcbranchE`, `jump_conflictE` and forwarded operands. Decides the actual branch outcome, checks it against the front-end prediction, and drives redirect/flush. Owns the 2-bit branch history table (BHT) that supplies `pred_takenF` to fetch and is trained from EX.

## Interface
- `BHT_DEPTH`, 64: BHT entries; power of two, ≥4.
- `CNT_W`, 32: width of the statistics counters.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stallE` in 1: EX stalled; no training, no statistics update.
- `branch_judge_controlE` in 5: branch code; 0 = not a branch.
- `pc_plus4E` in 32: branch PC + 4, which is the delay-slot address.
- `pcbranchE` in 32: branch target.
- `jump_conflictE` in 1: ID issued a jump in the shadow of this branch.
- `rs_valueE`, `rt_valueE` in 32: forwarded operands.
- `pred_takenE` in 1: prediction made at fetch for this instruction.
- `pcF` in 32: fetch PC for lookup.
- `pred_takenF` out 1: prediction for `pcF`.
- `actual_takenE` out 1: resolved outcome.
- `mispredictE` out 1: redirect required.
- `redirect_pcE` out 32: correct next-fetch PC.
- `flush_jumpE` out 1: discard the conflicting ID jump.
- `link_enE` out 1: write `pc_plus4E+4` to $31.
- `branch_cnt`, `mispredict_cnt` out `CNT_W`: resolved-branch and mispredict counts.

## Operation
- Codes: 1 BEQ (rs==rt), 2 BNE, 3 BGEZ (rs≥0 signed), 4 BGTZ, 5 BLEZ, 6 BLTZ, 7 BGEZAL, 8 BLTZAL. Codes 0 and 9–31 mean not-a-branch. Comparisons are 32-bit signed, against zero except BEQ/BNE.
- `is_br` = code in 1..8. `actual_takenE` = `is_br` & condition.
- `mispredictE` = `is_br` & (`actual_takenE` != `pred_takenE`).
- `redirect_pcE` = `pcbranchE` if taken, else `pc_plus4E + 4`. Fall-through skips the delay slot; add is mod 2^32.
- `link_enE` = code 7 or 8, regardless of outcome.
- `flush_jumpE` = `jump_conflictE` & `actual_takenE`. A taken branch wins over the younger jump. If not taken, the jump proceeds.
- BHT index: `pc[log2(BHT_DEPTH)+1:2]`. Fetch reads with `pcF`; EX trains with `pc_plus4E - 4`.
- 2-bit saturating counters, where prediction = MSB. Taken: increment, saturating at 3. Not taken: decrement, saturating at 0.
- Training happens when `is_br` & ~`stallE` & rst high.
- Read-during-write on the same index: `pred_takenF` reflects the new counter value (bypass).
- `branch_cnt` increments on every trained branch. `mispredict_cnt` increments when `mispredictE` is also high. Both saturate at all-ones.

## Timing
- Resolution outputs are combinational from EX inputs, with zero latency. They are consumed by ID/EX and IF/ID flush and by the PC mux in the same cycle.
- BHT and counter updates take effect at the edge ending the EX cycle.
- Reset (async assert, sync-to-clk deassert handled upstream):
  - every BHT entry goes to 01 (weakly not-taken);
  - both counters go to 0;
  - `pred_takenF` = 0 immediately.
- Reset asserted mid-stream aborts any pending training. Combinational outputs still follow their inputs.
- `stallE` high: outputs remain valid for the held instruction, and no state changes. This prevents double training.
- Bubble from `flushE` upstream arrives as code 0: no outputs assert, no state changes.

## Structure
- Package `branch_pkg`: branch code localparams (`BR_NONE`, `BR_BEQ`…`BR_BLTZAL`), counter state constants (`SNT=0`, `WNT=1`, `WT=2`, `ST=3`).
- One sub-module `bht_2bit` (`BHT_DEPTH` counters, async-low reset, one read port, one train port, bypass). Comparison, redirect and statistics logic live in the top.

## Test plan
- After reset, `pcF=0x00400000` → `pred_takenF=0`; counters 0.
- BEQ, rs=rt=5, `pred_takenE=0`, `pcbranchE=0x00400100` → `actual_takenE=1`, `mispredictE=1`, `redirect_pcE=0x00400100`, mispredict_cnt=1.
- BLTZ, rs=0x80000000, pred 1 → no mispredict. BLTZ, rs=0, pred 1, `pc_plus4E=0x00400014` → `redirect_pcE=0x00400018`.
- Train the same PC taken 3×: states 01→10→11→11, `pred_takenF` flips after the first. Then not-taken 2× → 01, `pred_takenF=0`. Check the bypass in the training cycle.
- BGEZAL with `jump_conflictE=1`, taken → `flush_jumpE=1`, `link_enE=1`. Same instruction not taken → `flush_jumpE=0`, `link_enE=1`.
- `stallE=1` for 3 cycles on one branch → `branch_cnt` +1 only. Assert `rst` mid-stall → all counters 0 and BHT 01 asynchronously.
